// File: rtl/prod2_mult_engine.sv
// ---------------------------------------------------------------------------
// prod2_mult_engine
//
// Fixed-function responder for the start/done handshake. A falling edge of
// start launches one run. The engine reads two signed 8-bit operands from
// data memory, forms their 16-bit two's-complement product with an
// iterative shift-add multiplier, and writes the product back little-endian.
// It then raises done and holds it until start returns high.
//
// Optional build macro:
//   PROD2_ZERO_SKIP_EN - when defined, a zero operand bypasses the multiply
//                        loop. The product (0) is written after 4 cycles
//                        instead of 12. Memory contents at done are the same
//                        in both builds.
//
// Ports:
//   clk        in   system clock, all state changes on the rising edge
//   reset      in   synchronous active-low reset
//   start      in   request; a 1->0 transition launches one run
//   done       out  acknowledge; high while the product is in memory
//   mem_addr   out  data memory address (ADDR_W bits)
//   mem_rdata  in   data memory read data, combinational from mem_addr
//   mem_wr_en  out  data memory write enable, write happens at the clk edge
//   mem_wdata  out  data memory write data
// ---------------------------------------------------------------------------
module prod2_mult_engine #(
  parameter int ADDR_W    = 8,
  parameter int OPA_ADDR  = 0,
  parameter int OPB_ADDR  = 1,
  parameter int PROD_ADDR = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              mem_wr_en,
  output logic [7:0]        mem_wdata
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_A,
    ST_RD_B,
    ST_MUL,
    ST_WR_LO,
    ST_WR_HI,
    ST_DONE
  } state_e;

  localparam logic [ADDR_W-1:0] OPA_A     = ADDR_W'(OPA_ADDR);
  localparam logic [ADDR_W-1:0] OPB_A     = ADDR_W'(OPB_ADDR);
  localparam logic [ADDR_W-1:0] PROD_LO_A = ADDR_W'(PROD_ADDR);
  localparam logic [ADDR_W-1:0] PROD_HI_A = ADDR_W'(PROD_ADDR + 1);

  state_e      state_q, state_d;
  logic        start_q;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [15:0] acc_q, acc_d;
  logic [2:0]  cnt_q, cnt_d;

  logic        launch;
  logic [15:0] mcand;

  assign launch = start_q & ~start;

  // Sign-extended A, weighted by the current bit position of B.
  assign mcand = {{8{a_q[7]}}, a_q} << cnt_q;

  // NOTE: state registers use non-blocking assignments so that every flop
  // samples the values from before the edge, regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: every signal driven here receives a default first. A path that
  // leaves one unassigned would otherwise infer a latch.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wr_en = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (launch) state_d = ST_RD_A;
      end

      ST_RD_A: begin
        mem_addr = OPA_A;
        a_d      = mem_rdata;
        state_d  = ST_RD_B;
      end

      ST_RD_B: begin
        mem_addr = OPB_A;
        b_d      = mem_rdata;
        acc_d    = '0;
        cnt_d    = '0;
`ifdef PROD2_ZERO_SKIP_EN
        // A zero operand gives a zero product, so the loop can be skipped.
        if (a_q == 8'd0 || mem_rdata == 8'd0) state_d = ST_WR_LO;
        else                                  state_d = ST_MUL;
`else
        state_d  = ST_MUL;
`endif
      end

      ST_MUL: begin
        // B's top bit carries weight -128, so its partial product is subtracted.
        if (b_q[cnt_q]) begin
          if (cnt_q == 3'd7) acc_d = acc_q - mcand;
          else               acc_d = acc_q + mcand;
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) state_d = ST_WR_LO;
      end

      ST_WR_LO: begin
        mem_addr  = PROD_LO_A;
        mem_wdata = acc_q[7:0];
        mem_wr_en = 1'b1;
        state_d   = ST_WR_HI;
      end

      ST_WR_HI: begin
        mem_addr  = PROD_HI_A;
        mem_wdata = acc_q[15:8];
        mem_wr_en = 1'b1;
        state_d   = ST_DONE;
      end

      ST_DONE: begin
        done = 1'b1;
        if (start) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_prod2_mult_engine.sv
// ---------------------------------------------------------------------------
// Bench for prod2_mult_engine. A behavioural byte memory sits on the memory
// port. Each vector record holds operands, the hand-computed 16-bit product,
// and whether an operand is zero, which sets the latency expected in the
// zero-skip build.
// ---------------------------------------------------------------------------
module tb_prod2_mult_engine;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       done;
  logic [7:0] mem_addr;
  logic [7:0] mem_rdata;
  logic       mem_wr_en;
  logic [7:0] mem_wdata;

  logic [7:0] mem [256];
  int         wr_count = 0;
  int         op_writes = 0;

  int n_checks = 0;
  int n_pass   = 0;

  prod2_mult_engine #(
    .ADDR_W(8), .OPA_ADDR(0), .OPB_ADDR(1), .PROD_ADDR(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_wr_en (mem_wr_en),
    .mem_wdata (mem_wdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_wr_en) begin
      mem[mem_addr] <= mem_wdata;
      wr_count++;
      if (mem_addr == 8'd0 || mem_addr == 8'd1) op_writes++;
    end
  end

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] prod;
    bit          zero;
  } vec_t;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  function automatic int exp_lat(input bit zero);
`ifdef PROD2_ZERO_SKIP_EN
    return zero ? 4 : 12;
`else
    return 12;
`endif
  endfunction

  // Loads operands and product sentinels, then drives start 1->0. It counts
  // clock edges after the launch edge E0 until done is seen (-1 on timeout).
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, output int lat);
    mem[0] = a;
    mem[1] = b;
    mem[2] = 8'hA5;
    mem[3] = 8'h5A;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic release_start(input string name);
    start = 1'b1;
    @(posedge clk);
    #1 check({name, "_done_drop"}, int'(done), 0);
  endtask

  vec_t vecs[11];
  int   lat;
  int   wr_snap;
  int   done_seen;

  initial begin
    vecs[0]  = '{8'h02, 8'hFC, 16'hFFF8, 1'b0};  //    2 *   -4 =    -8
    vecs[1]  = '{8'h80, 8'h80, 16'h4000, 1'b0};  // -128 * -128 = 16384
    vecs[2]  = '{8'h7F, 8'h80, 16'hC080, 1'b0};  //  127 * -128 = -16256
    vecs[3]  = '{8'hFF, 8'hFF, 16'h0001, 1'b0};  //   -1 *   -1 =     1
    vecs[4]  = '{8'h00, 8'h37, 16'h0000, 1'b1};  //    0 *   55 =     0
    vecs[5]  = '{8'h37, 8'h00, 16'h0000, 1'b1};  //   55 *    0 =     0
    vecs[6]  = '{8'hF9, 8'h09, 16'hFFC1, 1'b0};  //   -7 *    9 =   -63
    vecs[7]  = '{8'h64, 8'h64, 16'h2710, 1'b0};  //  100 *  100 = 10000
    vecs[8]  = '{8'h80, 8'h7F, 16'hC080, 1'b0};  // -128 *  127 = -16256
    vecs[9]  = '{8'h03, 8'h05, 16'h000F, 1'b0};  //    3 *    5 =    15
    vecs[10] = '{8'h01, 8'h80, 16'hFF80, 1'b0};  //    1 * -128 =  -128

    for (int i = 0; i < 256; i++) mem[i] = 8'h00;

    // Reset state.
    reset = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    check("rst_done",  int'(done),      0);
    check("rst_wr_en", int'(mem_wr_en), 0);
    check("rst_addr",  int'(mem_addr),  0);
    check("rst_wdata", int'(mem_wdata), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    // Table-driven products.
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, lat);
      check($sformatf("v%0d_latency", i), lat, exp_lat(vecs[i].zero));
      check($sformatf("v%0d_product", i), int'({mem[3], mem[2]}), int'(vecs[i].prod));
      check($sformatf("v%0d_operands", i), int'({mem[1], mem[0]}),
            int'({vecs[i].b, vecs[i].a}));
      release_start($sformatf("v%0d", i));
    end

    // done must hold while start stays low, then drop one cycle after start=1.
    run_op(8'hFF, 8'hFF, lat);
    check("hold_latency", lat, 12);
    repeat (5) @(posedge clk);
    #1 check("hold_done_high", int'(done), 1);
    check("hold_product", int'({mem[3], mem[2]}), 16'h0001);
    release_start("hold");

    // A one-cycle reset pulse in MUL (cnt==4) aborts the run cleanly.
    mem[0] = 8'h05;
    mem[1] = 8'hFD;
    mem[2] = 8'hA5;
    mem[3] = 8'h5A;
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);              // E0
    repeat (6) @(posedge clk);   // now in MUL with cnt==4
    wr_snap = wr_count;
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    check("abort_done",  int'(done),      0);
    check("abort_wr_en", int'(mem_wr_en), 0);
    check("abort_addr",  int'(mem_addr),  0);
    reset = 1'b1;
    repeat (15) @(posedge clk);
    #1;
    check("abort_no_write", wr_count - wr_snap, 0);
    check("abort_idle_done", int'(done), 0);
    run_op(8'h05, 8'hFD, lat);   // 5 * -3 = -15
    check("abort_rerun_latency", lat, 12);
    check("abort_rerun_product", int'({mem[3], mem[2]}), 16'hFFF1);
    release_start("abort_rerun");

    // Start already low at reset release: no falling edge, no run.
    reset = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    wr_snap   = wr_count;
    done_seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (done) done_seen++;
    end
    check("lowstart_done", done_seen, 0);
    check("lowstart_writes", wr_count - wr_snap, 0);

    check("operand_writes", op_writes, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
